// File: rtl/sum_seg7_scan.sv
// Operand adder with sequential double-dabble BCD conversion driving a multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).

module sum_seg7_digit (
   input  logic [3:0] nib,
   input  logic       blank,
   input  logic       ovf,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h00;
      if (ovf) begin
         seg = 7'h40;
      end else if (!blank) begin
         case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
         endcase
      end
   end
endmodule

module sum_seg7_scan #(
   parameter int W        = 4,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   input  logic              load,
   output logic              busy,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              ovf
);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 2);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
   state_t state, state_nxt;

   logic [W:0]               sum_sh;
   logic [BW-1:0]            bcd, bcd_adj;
   logic [CW-1:0]            bit_cnt;
   logic                     ovf_tmp;
   logic [DIGITS-1:0][3:0]   disp;
   logic                     start;

   // UPDATE lasts one cycle with busy already low, so a load there starts a new conversion
   assign start = load && (state != CONV);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = CONV;
         CONV:    if (bit_cnt == CW'(W)) state_nxt = UPDATE;
         UPDATE:  state_nxt = load ? CONV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CONV);
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
   end

   // A 1 leaving the top nibble means the result no longer fits in DIGITS decimal digits
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_sh  <= '0;
         bcd     <= '0;
         bit_cnt <= '0;
         ovf_tmp <= 1'b0;
         disp    <= '0;
         ovf     <= 1'b0;
      end else begin
         if (start) begin
            sum_sh  <= {1'b0, a} + {1'b0, b};
            bcd     <= '0;
            bit_cnt <= '0;
            ovf_tmp <= 1'b0;
         end else if (state == CONV) begin
            {bcd, sum_sh} <= {bcd_adj[BW-2:0], sum_sh, 1'b0};
            ovf_tmp       <= ovf_tmp | bcd_adj[BW-1];
            bit_cnt       <= bit_cnt + 1'b1;
         end
         if (state == UPDATE) begin
            disp <= bcd;
            ovf  <= ovf_tmp;
         end
      end
   end

   logic [PW-1:0]          presc;
   logic [IW-1:0]          idx, idx_nxt;
   logic                   wrap;
   logic [DIGITS-1:0][6:0] seg_dig;

   assign wrap = (presc == PW'(SCAN_DIV - 1));

   always_comb begin
      idx_nxt = idx;
      if (wrap) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS:0] hi_zero;
   assign hi_zero[DIGITS] = 1'b1;
`endif

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      logic blank;
`ifdef LEADING_ZERO_BLANK_EN
      assign hi_zero[k] = hi_zero[k+1] && (disp[k] == 4'd0);
      assign blank      = (k != 0) && hi_zero[k];
`else
      assign blank      = 1'b0;
`endif
      sum_seg7_digit u_dig (
         .nib   (disp[k]),
         .blank (blank),
         .ovf   (ovf),
         .seg   (seg_dig[k])
      );
   end

   // an/seg are looked up from the next index so they switch on the same edge as idx
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
         an    <= DIGITS'(1);
         seg   <= 7'h3F;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         idx   <= idx_nxt;
         an    <= DIGITS'(1) << idx_nxt;
         seg   <= seg_dig[idx_nxt];
      end
   end
endmodule

// File: tb/tb_sum_seg7_scan.sv
// Bench for sum_seg7_scan: W=4 and W=7 instances, table vectors, hand sequences and random sums vs a decimal model.
module tb_sum_seg7_scan;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic sel = 1'b0;

   logic       rst4 = 1'b1, load4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, ovf4;
   logic [6:0] seg4;
   logic [1:0] an4;

   logic       rst7 = 1'b1, load7 = 1'b0;
   logic [6:0] a7 = '0, b7 = '0;
   logic       busy7, ovf7;
   logic [6:0] seg7;
   logic [1:0] an7;

   sum_seg7_scan #(.W(4), .DIGITS(2), .SCAN_DIV(4)) dut4 (
      .clk(clk), .rst(rst4), .a(a4), .b(b4), .load(load4),
      .busy(busy4), .seg(seg4), .an(an4), .ovf(ovf4));

   sum_seg7_scan #(.W(7), .DIGITS(2), .SCAN_DIV(4)) dut7 (
      .clk(clk), .rst(rst7), .a(a7), .b(b7), .load(load7),
      .busy(busy7), .seg(seg7), .an(an7), .ovf(ovf7));

   logic       busy_s, ovf_s;
   logic [6:0] seg_s;
   logic [1:0] an_s;
   assign busy_s = sel ? busy7 : busy4;
   assign ovf_s  = sel ? ovf7  : ovf4;
   assign seg_s  = sel ? seg7  : seg4;
   assign an_s   = sel ? an7   : an4;

   localparam logic [6:0] DEC [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                       7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z1 = 7'h00;
`else
   localparam logic [6:0] Z1 = 7'h3F;
`endif

   typedef struct {
      int         a;
      int         b;
      bit         ovf;
      logic [6:0] s1;
      logic [6:0] s0;
   } vec_t;
   vec_t tbl [9];

   // Decimal model for a two-digit display
   function automatic logic [6:0] exp_seg(int sum, int k);
      int p;
      p = (k == 0) ? 1 : 10;
      if (sum > 99) return 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && sum < p) return 7'h00;
`endif
      return DEC[(sum / p) % 10];
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(int va, int vb, logic ld);
      if (sel) begin a7 = 7'(va); b7 = 7'(vb); load7 = ld; end
      else     begin a4 = 4'(va); b4 = 4'(vb); load4 = ld; end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_s && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_load(int va, int vb);
      int n;
      set_ab(va, vb, 1'b1);
      @(negedge clk);
      set_ab(va, vb, 1'b0);
      wait_idle(n);
      check("busy_len", n, sel ? 8 : 5);
      cyc(3);
   endtask

   task automatic read_seg(int k, output logic [6:0] s);
      int n;
      logic [1:0] want;
      want = 2'(1 << k);
      n = 0;
      while (an_s != want && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL scan_timeout digit=%0d an=%b", k, an_s);
      end
      s = seg_s;
   endtask

   task automatic check_disp(string name, bit eovf, logic [6:0] e1, logic [6:0] e0);
      logic [6:0] s;
      check({name, "_ovf"}, int'(ovf_s), int'(eovf));
      read_seg(0, s);
      check({name, "_d0"}, int'(s), int'(e0));
      read_seg(1, s);
      check({name, "_d1"}, int'(s), int'(e1));
   endtask

   initial begin
      int n, sa, sb, sum;
      tbl[0] = '{60, 50, 1'b1, 7'h40, 7'h40};
      tbl[1] = '{45, 54, 1'b0, 7'h6F, 7'h6F};
      tbl[2] = '{0, 0, 1'b0, Z1, 7'h3F};
      tbl[3] = '{9, 8, 1'b0, 7'h06, 7'h07};
      tbl[4] = '{127, 127, 1'b1, 7'h40, 7'h40};
      tbl[5] = '{50, 49, 1'b0, 7'h6F, 7'h6F};
      tbl[6] = '{50, 50, 1'b1, 7'h40, 7'h40};
      tbl[7] = '{5, 4, 1'b0, Z1, 7'h6F};
      tbl[8] = '{10, 0, 1'b0, 7'h06, 7'h3F};

      // reset and scan timing
      cyc(2);
      rst4 = 1'b0;
      rst7 = 1'b0;
      check("rst_an", int'(an4), 1);
      check("rst_seg", int'(seg4), 'h3F);
      check("rst_busy", int'(busy4), 0);
      check("rst_ovf", int'(ovf4), 0);
      cyc(3);
      check("scan_hold", int'(an4), 1);
      cyc(1);
      check("scan_adv", int'(an4), 2);
      cyc(4);
      check("scan_wrap", int'(an4), 1);

      // W=4 sequences
      run_load(9, 8);
      check_disp("w4_17", 1'b0, 7'h06, 7'h07);
      run_load(0, 0);
      check_disp("w4_00", 1'b0, Z1, 7'h3F);

      // load while busy is dropped
      set_ab(3, 4, 1'b1);
      @(negedge clk);
      set_ab(15, 15, 1'b1);
      @(negedge clk);
      set_ab(15, 15, 1'b0);
      wait_idle(n);
      cyc(3);
      check_disp("w4_ignore", 1'b0, Z1, 7'h07);

      // reset mid-conversion
      run_load(15, 15);
      set_ab(15, 15, 1'b1);
      @(negedge clk);
      set_ab(15, 15, 1'b0);
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      check("abort_busy", int'(busy4), 0);
      check("abort_an", int'(an4), 1);
      check("abort_seg", int'(seg4), 'h3F);
      check_disp("abort_disp", 1'b0, Z1, 7'h3F);
      run_load(15, 15);
      check_disp("w4_30", 1'b0, 7'h4F, 7'h3F);

      // W=7 table vectors
      sel = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_load(tbl[i].a, tbl[i].b);
         check_disp($sformatf("tbl%0d", i), tbl[i].ovf, tbl[i].s1, tbl[i].s0);
      end

      // W=7 random sums against the decimal model
      for (int i = 0; i < 30; i++) begin
         sa = int'($urandom_range(127));
         sb = (i % 3 == 0) ? int'($urandom_range(99 - (sa % 100))) : int'($urandom_range(127));
         sum = sa + sb;
         run_load(sa, sb);
         check_disp($sformatf("rnd%0d_%0d", i, sum), sum > 99, exp_seg(sum, 1), exp_seg(sum, 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sum_seg7_scan.md
Name: sum_seg7_scan

Overview:
- Parametrised successor of the 2-bit add-and-display datapath.
- Registers two W-bit operands on a load strobe and adds them.
- Converts the sum to BCD sequentially using double-dabble, one bit per clock.
- Drives a time-multiplexed DIGITS-wide 7-segment display, with overflow indication and optional leading-zero blanking.
- Sits between operand sources (switches/regs) and the board display pins.

Parameters:
W, 4, operand width in bits (sum is W+1 bits)
DIGITS, 2, number of display digits, 1..8
SCAN_DIV, 1000, clocks each digit stays enabled, >=2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
a  in  W  operand A, sampled on load
b  in  W  operand B, sampled on load
load  in  1  single-cycle request to capture a, b and start conversion
busy  out  1  high while conversion in progress
seg  out  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}
an  out  DIGITS  digit enable, one-hot, active-high, bit 0 = least significant digit
ovf  out  1  high when the displayed result exceeds 10^DIGITS-1

Behaviour:
- Reset (rst high at a clk edge, synchronous, active-high):
  - FSM=IDLE, busy=0, ovf=0.
  - Display BCD register=all zero, scan prescaler=0, digit index=0.
  - an=1 (digit 0), seg=7'h3F.
  - Reset mid-conversion aborts; previous display contents are discarded.
- FSM states IDLE, CONV, UPDATE:
  - IDLE: load=1 -> capture sum=a+b (W+1 bits, no truncation). Clear BCD shift reg, bit count=0, clear ovf_tmp. Go to CONV; busy=1 from the next cycle.
  - CONV, one bit per clock, W+1 iterations:
    - Add 3 to every BCD nibble >=5.
    - Shift {bcd, sum} left by 1.
    - Any 1 shifted out of the top BCD nibble sets ovf_tmp (sticky).
    - After the (W+1)th shift go to UPDATE.
  - UPDATE: copy BCD to display register, ovf<=ovf_tmp, busy<=0, go to IDLE.
- load while busy is ignored; no queueing.
- Latency: load sampled at edge t -> display register and ovf valid after edge t+W+2. busy is high for exactly W+1 cycles.
- Scanning (runs continuously, independent of FSM):
  - Prescaler counts 0..SCAN_DIV-1.
  - On wrap, digit index increments; DIGITS-1 wraps to 0.
  - an and seg are registered and change on the same edge as the index.
  - an = 1 << index; seg = decode(display digit[index]).
- Decode table:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
  - Nibble >9 is unreachable; map it to 7'h00.
- Overflow display: when ovf=1, every digit shows 7'h40 (dash) regardless of the BCD contents.
- Display contents change only in UPDATE; the scan phase is not disturbed by a new result.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: any digit k>0 whose value and all higher digits are zero drives seg=7'h00 while selected. Digit 0 is never blanked. No effect when ovf=1.
- Not defined: all digits are always decoded; zeros show 7'h3F.

Test Plan:
1. W=4, DIGITS=2, SCAN_DIV=4; rst high 2 cycles -> an=2'b01, seg=7'h3F, busy=0, ovf=0. an advances to 2'b10 after 4 clocks and wraps back to 2'b01 after 8.
2. a=9, b=8, load 1 cycle -> busy=1 for exactly 5 cycles. Then an=01 gives seg=7'h07 and an=10 gives seg=7'h06 (17); ovf=0.
3. a=0, b=0, load -> both digits 7'h3F. With LEADING_ZERO_BLANK_EN, digit 1 shows 7'h00 and digit 0 shows 7'h3F.
4. W=7, DIGITS=2: a=60, b=50, load -> ovf=1, both digits 7'h40. Then a=45, b=54, load -> ovf=0, display 99 (7'h6F, 7'h6F).
5. load a=3, b=4, then load a=15, b=15 while busy -> second load ignored; display 07.
6. rst asserted mid-conversion (2 cycles after load a=15, b=15) -> busy=0, display 00, an=01. A fresh load a=15, b=15 then gives 30 (digit1=7'h4F, digit0=7'h3F).
